// File: rtl/serial_integrator_mc.sv
// serial_integrator_mc: multi-channel digit-serial two's-complement integrator with load, overflow and framing check
module serial_integrator_mc #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4,
  parameter int CH = 2,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1,
  localparam int DW = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int DEPTH = CH * WORDS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_digit_i,
  input  logic             in_first_i,
  input  logic             in_clear_i,
  input  logic [CH-1:0]    ovf_clear_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_digit_o,
  output logic             out_lsw_o,
  output logic             out_msw_o,
  output logic [CW-1:0]    out_chan_o,
  output logic [CH-1:0]    ovf_o,
  output logic             sync_err_o
);
  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];
  logic             carry_q, carry_d;
  logic [DW-1:0]    digit_q, digit_d;
  logic [CW-1:0]    chan_q, chan_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_digit_q, out_digit_d;
  logic             out_lsw_q, out_lsw_d;
  logic             out_msw_q, out_msw_d;
  logic [CW-1:0]    out_chan_q, out_chan_d;
  logic [CH-1:0]    ovf_q, ovf_d;
  logic             sync_q, sync_d;
  logic             resync, lsw, msw, ovf_hit;
  logic [DW-1:0]    di;
  logic [CW-1:0]    ci;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;

  // An off-frame in_first restarts the counters at (0,0) without realigning storage
  always_comb begin
    resync = in_valid_i && in_first_i && (chan_q != '0 || digit_q != '0);
    di = resync ? '0 : digit_q;
    ci = resync ? '0 : chan_q;
    lsw = di == '0;
    msw = di == DW'(WORDS - 1);
    opb = in_clear_i ? '0 : sr_q[0];
    sum = {1'b0, in_digit_i} + {1'b0, opb} + {{WIDTH{1'b0}}, lsw ? 1'b0 : carry_q};
    ovf_hit = in_valid_i && msw && (in_digit_i[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != in_digit_i[WIDTH-1]);
    for (int i = 0; i < DEPTH - 1; i++) sr_d[i] = in_valid_i ? sr_q[i+1] : sr_q[i];
    sr_d[DEPTH-1] = in_valid_i ? sum[WIDTH-1:0] : sr_q[DEPTH-1];
    carry_d = in_valid_i ? sum[WIDTH] : carry_q;
    digit_d = !in_valid_i ? digit_q : msw ? '0 : di + 1'b1;
    chan_d = !in_valid_i ? chan_q : !msw ? ci : (ci == CW'(CH - 1)) ? '0 : ci + 1'b1;
    out_valid_d = in_valid_i;
    out_digit_d = in_valid_i ? sum[WIDTH-1:0] : out_digit_q;
    out_lsw_d = in_valid_i ? lsw : out_lsw_q;
    out_msw_d = in_valid_i ? msw : out_msw_q;
    out_chan_d = in_valid_i ? ci : out_chan_q;
    ovf_d = (ovf_q & ~ovf_clear_i) | (ovf_hit ? CH'(1) << ci : '0);
    sync_d = sync_q | resync;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      carry_q <= 1'b0;
      digit_q <= '0;
      chan_q <= '0;
      out_valid_q <= 1'b0;
      out_digit_q <= '0;
      out_lsw_q <= 1'b0;
      out_msw_q <= 1'b0;
      out_chan_q <= '0;
      ovf_q <= '0;
      sync_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= sr_d[i];
      carry_q <= carry_d;
      digit_q <= digit_d;
      chan_q <= chan_d;
      out_valid_q <= out_valid_d;
      out_digit_q <= out_digit_d;
      out_lsw_q <= out_lsw_d;
      out_msw_q <= out_msw_d;
      out_chan_q <= out_chan_d;
      ovf_q <= ovf_d;
      sync_q <= sync_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_digit_o = out_digit_q;
  assign out_lsw_o = out_lsw_q;
  assign out_msw_o = out_msw_q;
  assign out_chan_o = out_chan_q;
  assign ovf_o = ovf_q;
  assign sync_err_o = sync_q;
endmodule

// File: tb/tb_serial_integrator_mc.sv
// tb_serial_integrator_mc: directed plan plus random traffic against a digit-queue reference model
module tb_serial_integrator_mc;
  localparam int WIDTH = 4, WORDS = 2, CH = 2, CW = 1;
  localparam int DEPTH = CH * WORDS;
  localparam int MOD = 1 << WIDTH;
  logic clock = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_first = 1'b0, in_clear = 1'b0;
  logic [WIDTH-1:0] in_digit = '0;
  logic [CH-1:0] ovf_clear = '0;
  logic out_valid, out_lsw, out_msw, sync_err;
  logic [WIDTH-1:0] out_digit;
  logic [CW-1:0] out_chan;
  logic [CH-1:0] ovf;
  int ncmp = 0, nfail = 0;
  int q[$];
  int carry, md, mc;
  int e_valid, e_digit, e_lsw, e_msw, e_chan, e_ovf, e_sync;

  serial_integrator_mc #(.WIDTH(WIDTH), .WORDS(WORDS), .CH(CH)) dut (
    .clock(clock), .reset(reset), .in_valid_i(in_valid), .in_digit_i(in_digit),
    .in_first_i(in_first), .in_clear_i(in_clear), .ovf_clear_i(ovf_clear),
    .out_valid_o(out_valid), .out_digit_o(out_digit), .out_lsw_o(out_lsw),
    .out_msw_o(out_msw), .out_chan_o(out_chan), .ovf_o(ovf), .sync_err_o(sync_err));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(0);
    carry = 0; md = 0; mc = 0;
    e_valid = 0; e_digit = 0; e_lsw = 0; e_msw = 0; e_chan = 0; e_ovf = 0; e_sync = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, int'(out_valid), e_valid);
    chk({tag, ".digit"}, int'(out_digit), e_digit);
    chk({tag, ".lsw"}, int'(out_lsw), e_lsw);
    chk({tag, ".msw"}, int'(out_msw), e_msw);
    chk({tag, ".chan"}, int'(out_chan), e_chan);
    chk({tag, ".ovf"}, int'(ovf), e_ovf);
    chk({tag, ".sync"}, int'(sync_err), e_sync);
  endtask

  function automatic int sgn(input int x);
    return (x >= MOD / 2) ? x - MOD : x;
  endfunction

  // One clock of stimulus; the model applies the behaviour of an accepted digit with integer arithmetic
  task automatic step(input bit v, input int dig, input bit f, input bit clr, input int oclr);
    int head, b, cin, s, setm;
    in_valid = v; in_digit = WIDTH'(dig); in_first = f; in_clear = clr; ovf_clear = CH'(oclr);
    setm = 0;
    if (v) begin
      if (f && (mc != 0 || md != 0)) begin
        e_sync = 1; mc = 0; md = 0;
      end
      head = q.pop_front();
      b = clr ? 0 : head;
      cin = (md == 0) ? 0 : carry;
      s = dig + b + cin;
      q.push_back(s % MOD);
      carry = s / MOD;
      e_digit = s % MOD; e_lsw = (md == 0); e_msw = (md == WORDS - 1); e_chan = mc;
      if (md == WORDS - 1) begin
        int r = sgn(dig) + sgn(b) + cin;
        if (r > MOD / 2 - 1 || r < -MOD / 2) setm = 1 << mc;
      end
      md++;
      if (md == WORDS) begin md = 0; mc = (mc + 1) % CH; end
    end
    e_valid = v;
    e_ovf = (e_ovf & ~oclr) | setm;
    @(posedge clock); #1;
    check_all("step");
    in_valid = 0; in_first = 0; in_clear = 0; ovf_clear = '0;
  endtask

  task automatic sample(input int val, input bit clr);
    for (int k = 0; k < WORDS; k++)
      step(1, (val >> (k * WIDTH)) % MOD, (mc == 0 && md == 0), clr, 0);
  endtask

  initial begin
    model_reset();
    reset = 1;
    @(posedge clock); @(posedge clock); #1;
    check_all("reset");
    reset = 0;
    // 1: carry propagation
    sample(8'h0F, 0); sample(8'h00, 0);
    step(1, 4'hF, 1, 0, 0);
    chk("t1.lsw_digit", int'(out_digit), 4'hE); chk("t1.lsw_flag", int'(out_lsw), 1); chk("t1.chan", int'(out_chan), 0);
    step(1, 4'h0, 0, 0, 0);
    chk("t1.msw_digit", int'(out_digit), 4'h1); chk("t1.msw_flag", int'(out_msw), 1); chk("t1.ovf", int'(ovf), 0);
    // 2: channel and carry isolation
    sample(8'hFF, 0); sample(8'h00, 0);
    step(1, 4'h1, 0, 0, 0); chk("t2.d0", int'(out_digit), 0);
    step(1, 4'h0, 0, 0, 0); chk("t2.d1", int'(out_digit), 0); chk("t2.ovf", int'(ovf), 0);
    step(1, 4'h0, 1, 0, 0); chk("t2.ch0_lsw", int'(out_digit), 4'hE);
    step(1, 4'h0, 0, 0, 0);
    // 3: overflow, clear, set-wins
    sample(8'h70, 0); sample(8'h00, 0); sample(8'h70, 0);
    chk("t3.res", int'(out_digit), 4'hE); chk("t3.ovf_set", int'(ovf), 2'b10);
    step(1, 0, 1, 0, 2'b10); chk("t3.ovf_clr", int'(ovf), 0);
    step(1, 0, 0, 0, 0);
    step(1, 4'h0, 0, 0, 0); step(1, 4'h8, 0, 0, 2'b10);
    chk("t3.set_wins", int'(ovf), 2'b10);
    // 4: load mode
    sample(8'h33, 1); sample(8'h00, 0);
    step(1, 4'h5, 1, 1, 0); chk("t4.l0", int'(out_digit), 5);
    step(1, 4'h0, 0, 1, 0); chk("t4.l1", int'(out_digit), 0);
    sample(8'h00, 0);
    step(1, 4'h1, 1, 0, 0); chk("t4.a0", int'(out_digit), 6);
    step(1, 4'h0, 0, 0, 0); chk("t4.a1", int'(out_digit), 0);
    // 5: hold then off-frame first
    step(1, 4'h2, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'h9, 1, 1, 0); chk("t5.hold_valid", int'(out_valid), 0); chk("t5.hold_digit", int'(out_digit), 4'h2);
    end
    step(1, 4'h0, 0, 0, 0);
    step(1, 4'h3, 0, 0, 0);
    step(1, 4'h1, 1, 0, 0);
    chk("t5.sync", int'(sync_err), 1); chk("t5.chan", int'(out_chan), 0); chk("t5.lsw", int'(out_lsw), 1);
    // 6: reset mid-sample
    step(1, 4'h7, 0, 0, 0);
    step(1, 4'h4, 0, 0, 0);
    reset = 1; in_valid = 1;
    @(posedge clock); #1;
    model_reset();
    check_all("t6.reset");
    reset = 0; in_valid = 0;
    sample(8'h25, 0);
    chk("t6.fresh", int'(out_digit), 2);
    // random traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(3, 0) != 0, $urandom_range(MOD - 1, 0), $urandom_range(19, 0) == 0,
           $urandom_range(9, 0) == 0, ($urandom_range(9, 0) == 0) ? $urandom_range(3, 0) : 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
